leaf_router_nport: RTL and testbench

Parametrised leaf router joining one local GPU network interface to NUM_SPINES spine links. Every input port has a FIFO. Spine traffic addressed to LOCAL_ADDR goes to the local port; spine traffic for any other address is dropped and counted. Local traffic for another address goes up to a spine, chosen either by address bits or by round-robin. All ports use valid/ready handshakes; this block replaces the fixed 4-spine, unbuffered leaf router in the GPU/NI/router top.

---
 rtl/leaf_router_nport.sv | 203 ++++++++++++++++++++
 tb/tb_leaf_router_nport.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_router_nport.sv
// leaf_router_nport
//   Leaf router that joins one local GPU network interface to NUM_SPINES
//   spine links. Each input port has its own FIFO, and each output port has
//   one output register.
//   - Spine packets addressed to LOCAL_ADDR are forwarded to the local port.
//   - Spine packets with any other address are dropped and counted.
//   - Local packets addressed to LOCAL_ADDR loop back to the local port.
//   - Other local packets go up to one spine. The spine is picked from the
//     address bits (SPINE_SEL=0) or by round-robin (SPINE_SEL=1).
//
// Ports
//   ACLK, ARESET                      clock; synchronous active-high reset
//   local_in_data/valid/ready         packet stream from the NI
//   local_out_data/valid/ready        packet stream to the NI
//   spine_in_data/valid/ready         per-spine input streams;
//                                     port i uses [i*DATA_W +: DATA_W]
//   spine_out_data/valid/ready        per-spine output streams
//   drop_count                        filtered spine packets, saturating
module leaf_router_nport #(
    parameter int unsigned             DATA_W     = 16,
    parameter int unsigned             ADDR_W     = 6,
    parameter logic [ADDR_W-1:0]       LOCAL_ADDR = 6'b000100,
    parameter int unsigned             NUM_SPINES = 4,
    parameter int unsigned             FIFO_DEPTH = 4,
    parameter int unsigned             SPINE_SEL  = 0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [DATA_W-1:0]              local_in_data,
    input  logic                           local_in_valid,
    output logic                           local_in_ready,
    output logic [DATA_W-1:0]              local_out_data,
    output logic                           local_out_valid,
    input  logic                           local_out_ready,
    input  logic [NUM_SPINES*DATA_W-1:0]   spine_in_data,
    input  logic [NUM_SPINES-1:0]          spine_in_valid,
    output logic [NUM_SPINES-1:0]          spine_in_ready,
    output logic [NUM_SPINES*DATA_W-1:0]   spine_out_data,
    output logic [NUM_SPINES-1:0]          spine_out_valid,
    input  logic [NUM_SPINES-1:0]          spine_out_ready,
    output logic [15:0]                    drop_count
);

    // Input port 0 is the local port. Ports 1..NUM_SPINES are the spines.
    localparam int unsigned NP = NUM_SPINES + 1;
    localparam int unsigned SW = $clog2(NUM_SPINES);
    localparam int unsigned PW = $clog2(NP);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // ---------------- input FIFOs ----------------
    logic [DATA_W-1:0] mem [NP][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [NP];
    logic [AW-1:0]     rd_ptr [NP];
    logic [CW-1:0]     count  [NP];

    logic [DATA_W-1:0] in_data   [NP];
    logic [DATA_W-1:0] head_data [NP];
    logic [NP-1:0]     in_valid, in_ready, push, pop, head_valid, head_local;

    always_comb begin
        in_data[0] = local_in_data;
        for (int unsigned i = 0; i < NUM_SPINES; i++) begin
            in_data[i+1] = spine_in_data[i*DATA_W +: DATA_W];
        end
    end

    assign in_valid = {spine_in_valid, local_in_valid};

    always_comb begin
        in_ready   = '0;
        head_valid = '0;
        head_local = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            // ready follows only the registered count, so a pop in the
            // same cycle does not free space for a push.
            in_ready[p]   = !ARESET && (count[p] != CW'(FIFO_DEPTH));
            head_data[p]  = mem[p][rd_ptr[p]];
            head_valid[p] = (count[p] != '0);
            head_local[p] = (head_data[p][DATA_W-1 -: ADDR_W] == LOCAL_ADDR);
        end
    end

    assign push           = in_valid & in_ready;
    assign local_in_ready = in_ready[0];
    assign spine_in_ready = in_ready[NP-1:1];

    always_ff @(posedge ACLK) begin
        for (int unsigned p = 0; p < NP; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= in_data[p];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int unsigned p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + 1'b1;
                    2'b01:   count[p] <= count[p] - 1'b1;
                    default: count[p] <= count[p];
                endcase
            end
        end
    end

    // ---------------- routing decisions ----------------
    logic [SW-1:0]         rr_spine;
    logic [SW-1:0]         up_target;
    logic [NUM_SPINES-1:0] spine_ok;
    logic                  up_load;
    logic [NUM_SPINES-1:0] drops;
    logic [NP-1:0]         req;

    assign spine_ok  = ~spine_out_valid | spine_out_ready;
    assign up_target = (SPINE_SEL == 1) ? rr_spine
                                        : head_data[0][DATA_W-ADDR_W +: SW];
    // A non-local local packet waits at the head until its spine can load.
    assign up_load   = head_valid[0] && !head_local[0] && spine_ok[up_target];
    assign req       = head_valid & head_local;
    assign drops     = head_valid[NP-1:1] & ~head_local[NP-1:1];

    // ---------------- local_out round-robin arbiter ----------------
    logic [PW-1:0] arb_ptr;
    logic [PW-1:0] grant_idx;
    logic          grant_valid;
    logic          local_load;

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        // Search starts at arb_ptr. The first requester found wins.
        for (int unsigned k = 0; k < NP; k++) begin
            idx = (int'(arb_ptr) + k) % NP;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    assign local_load = grant_valid && (!local_out_valid || local_out_ready);

    always_comb begin
        pop    = '0;
        pop[0] = up_load;
        for (int unsigned i = 0; i < NUM_SPINES; i++) begin
            pop[i+1] = drops[i];
        end
        if (local_load) pop[grant_idx] = 1'b1;
    end

    // ---------------- output registers and counters ----------------
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_count} + 17'($countones(drops));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            local_out_data  <= '0;
            local_out_valid <= 1'b0;
            spine_out_data  <= '0;
            spine_out_valid <= '0;
            arb_ptr         <= '0;
            rr_spine        <= '0;
            drop_count      <= '0;
        end else begin
            if (local_load) begin
                local_out_data  <= head_data[grant_idx];
                local_out_valid <= 1'b1;
                arb_ptr         <= (grant_idx == PW'(NP - 1)) ? '0 : grant_idx + 1'b1;
            end else if (local_out_ready) begin
                local_out_valid <= 1'b0;
            end

            for (int unsigned i = 0; i < NUM_SPINES; i++) begin
                if (up_load && (up_target == SW'(i))) begin
                    spine_out_data[i*DATA_W +: DATA_W] <= head_data[0];
                    spine_out_valid[i]                 <= 1'b1;
                end else if (spine_out_ready[i]) begin
                    spine_out_valid[i] <= 1'b0;
                end
            end

            // NUM_SPINES is a power of two, so rr_spine wraps naturally.
            if (up_load && (SPINE_SEL == 1)) rr_spine <= rr_spine + 1'b1;

            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_leaf_router_nport.sv
module tb_leaf_router_nport;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT 0: address-hashed uplink
    logic        rst;
    logic [15:0] local_in_data;
    logic        local_in_valid;
    logic        local_in_ready;
    logic [15:0] local_out_data;
    logic        local_out_valid;
    logic        local_out_ready;
    logic [63:0] spine_in_data;
    logic [3:0]  spine_in_valid;
    logic [3:0]  spine_in_ready;
    logic [63:0] spine_out_data;
    logic [3:0]  spine_out_valid;
    logic [3:0]  spine_out_ready;
    logic [15:0] drop_count;

    // DUT 1: round-robin uplink
    logic        m_rst;
    logic [15:0] m_local_in_data;
    logic        m_local_in_valid;
    logic        m_local_in_ready;
    logic [15:0] m_local_out_data;
    logic        m_local_out_valid;
    logic        m_local_out_ready;
    logic [63:0] m_spine_in_data;
    logic [3:0]  m_spine_in_valid;
    logic [3:0]  m_spine_in_ready;
    logic [63:0] m_spine_out_data;
    logic [3:0]  m_spine_out_valid;
    logic [3:0]  m_spine_out_ready;
    logic [15:0] m_drop_count;

    leaf_router_nport #(.SPINE_SEL(0)) u0 (
        .ACLK(clk), .ARESET(rst),
        .local_in_data(local_in_data), .local_in_valid(local_in_valid),
        .local_in_ready(local_in_ready),
        .local_out_data(local_out_data), .local_out_valid(local_out_valid),
        .local_out_ready(local_out_ready),
        .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid),
        .spine_in_ready(spine_in_ready),
        .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid),
        .spine_out_ready(spine_out_ready),
        .drop_count(drop_count)
    );

    leaf_router_nport #(.SPINE_SEL(1)) u1 (
        .ACLK(clk), .ARESET(m_rst),
        .local_in_data(m_local_in_data), .local_in_valid(m_local_in_valid),
        .local_in_ready(m_local_in_ready),
        .local_out_data(m_local_out_data), .local_out_valid(m_local_out_valid),
        .local_out_ready(m_local_out_ready),
        .spine_in_data(m_spine_in_data), .spine_in_valid(m_spine_in_valid),
        .spine_in_ready(m_spine_in_ready),
        .spine_out_data(m_spine_out_data), .spine_out_valid(m_spine_out_valid),
        .spine_out_ready(m_spine_out_ready),
        .drop_count(m_drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return 1 ns after it (sample/drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saw;

        rst = 1'b1; m_rst = 1'b1;
        local_in_data = '0; local_in_valid = 1'b0; local_out_ready = 1'b1;
        spine_in_data = '0; spine_in_valid = '0; spine_out_ready = 4'hF;
        m_local_in_data = '0; m_local_in_valid = 1'b0; m_local_out_ready = 1'b1;
        m_spine_in_data = '0; m_spine_in_valid = '0; m_spine_out_ready = 4'hF;

        // ---- reset state ----
        tick(); tick();
        chk("rst_local_ready", {31'd0, local_in_ready}, 32'd0);
        chk("rst_spine_ready", {28'd0, spine_in_ready}, 32'd0);
        chk("rst_out_valid", {27'd0, local_out_valid, spine_out_valid}, 32'd0);
        rst = 1'b0; m_rst = 1'b0;
        tick();
        chk("post_rst_local_ready", {31'd0, local_in_ready}, 32'd1);
        chk("post_rst_spine_ready", {28'd0, spine_in_ready}, 32'hF);
        chk("post_rst_local_data", {16'd0, local_out_data}, 32'd0);
        chk("post_rst_spine_data_lo", spine_out_data[31:0], 32'd0);
        chk("post_rst_spine_data_hi", spine_out_data[63:32], 32'd0);
        chk("post_rst_drop", {16'd0, drop_count}, 32'd0);

        // ---- uplink, mode 0: addr 000101 -> spine 1 ----
        local_in_data = 16'h1555; local_in_valid = 1'b1;
        tick();
        local_in_valid = 1'b0;
        chk("up_not_early", {28'd0, spine_out_valid}, 32'd0);
        tick();
        chk("up_valid", {28'd0, spine_out_valid}, 32'b0010);
        chk("up_data", {16'd0, spine_out_data[16 +: 16]}, 32'h1555);
        tick();
        chk("up_done", {28'd0, spine_out_valid}, 32'd0);

        // ---- downlink: spine 2, addr 000100 -> local ----
        spine_in_data[32 +: 16] = 16'h12AB; spine_in_valid = 4'b0100;
        tick();
        spine_in_valid = '0;
        chk("down_not_early", {31'd0, local_out_valid}, 32'd0);
        tick();
        chk("down_valid", {31'd0, local_out_valid}, 32'd1);
        chk("down_data", {16'd0, local_out_data}, 32'h12AB);
        chk("down_drop", {16'd0, drop_count}, 32'd0);
        tick();
        chk("down_done", {31'd0, local_out_valid}, 32'd0);

        // ---- filter: spine 3, addr 000101 -> dropped ----
        spine_in_data[48 +: 16] = 16'h17CD; spine_in_valid = 4'b1000;
        tick();
        spine_in_valid = '0;
        tick();
        chk("filter_drop1", {16'd0, drop_count}, 32'd1);
        saw = 0;
        for (int i = 0; i < 50; i++) begin
            if (local_out_valid) saw++;
            tick();
        end
        chk("filter_no_out", saw, 32'd0);

        // Four simultaneous drops per cycle for 10 cycles: +40
        for (int i = 0; i < 4; i++) spine_in_data[i*16 +: 16] = 16'h17C0 + 16'(i);
        spine_in_valid = 4'hF;
        for (int i = 0; i < 10; i++) tick();
        spine_in_valid = '0;
        tick();
        chk("multi_drop", {16'd0, drop_count}, 32'd41);

        // 70000 more drops -> saturation
        spine_in_valid = 4'hF;
        for (int i = 0; i < 17500; i++) tick();
        spine_in_valid = '0;
        tick();
        chk("drop_saturate", {16'd0, drop_count}, 32'h0000FFFF);

        // ---- fairness: loopback + 4 spines all requesting local ----
        rst = 1'b1; tick(); rst = 1'b0;
        chk("fair_rst_drop", {16'd0, drop_count}, 32'd0);
        local_in_data = 16'h1000; local_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) spine_in_data[i*16 +: 16] = 16'h1001 + 16'(i);
        spine_in_valid = 4'hF;
        tick();
        for (int j = 0; j < 10; j++) begin
            tick();
            chk($sformatf("fair_grant%0d", j), {15'd0, local_out_valid, local_out_data},
                {15'd0, 1'b1, 16'h1000 + 16'(j % 5)});
        end
        local_in_valid = 1'b0; spine_in_valid = '0;
        rst = 1'b1; tick(); rst = 1'b0;

        // ---- backpressure on spine 1 ----
        spine_out_ready = 4'b1101;
        for (int n = 0; n < 5; n++) begin
            local_in_data = 16'h1401 + 16'(n); local_in_valid = 1'b1;
            tick();
        end
        chk("bp_ready_low", {31'd0, local_in_ready}, 32'd0);
        chk("bp_held_valid", {28'd0, spine_out_valid}, 32'b0010);
        chk("bp_held_data", {16'd0, spine_out_data[16 +: 16]}, 32'h1401);
        local_in_data = 16'h1406;
        tick();
        chk("bp_refused", {31'd0, local_in_ready}, 32'd0);
        chk("bp_stable", {16'd0, spine_out_data[16 +: 16]}, 32'h1401);
        spine_out_ready = 4'hF;
        tick();
        chk("bp_out2", {15'd0, spine_out_valid[1], spine_out_data[16 +: 16]}, {15'd0, 1'b1, 16'h1402});
        tick();
        local_in_valid = 1'b0;
        chk("bp_out3", {15'd0, spine_out_valid[1], spine_out_data[16 +: 16]}, {15'd0, 1'b1, 16'h1403});
        for (int n = 4; n <= 6; n++) begin
            tick();
            chk($sformatf("bp_out%0d", n), {15'd0, spine_out_valid[1], spine_out_data[16 +: 16]},
                {15'd0, 1'b1, 16'h1400 + 16'(n)});
        end
        tick();
        chk("bp_drained", {28'd0, spine_out_valid}, 32'd0);

        // ---- mode 1: round-robin spine selection ----
        for (int n = 0; n < 5; n++) begin
            m_local_in_data = 16'h1421 + 16'(n); m_local_in_valid = 1'b1;
            tick();
            if (n > 0)
                chk($sformatf("rr_valid%0d", n - 1), {28'd0, m_spine_out_valid},
                    32'(1 << ((n - 1) % 4)));
        end
        m_local_in_valid = 1'b0;
        tick();
        chk("rr_valid4", {28'd0, m_spine_out_valid}, 32'b0001);
        chk("rr_data4", {16'd0, m_spine_out_data[15:0]}, 32'h1425);
        chk("rr_data3", {16'd0, m_spine_out_data[48 +: 16]}, 32'h1424);
        tick();

        // ---- reset mid-burst ----
        for (int n = 0; n < 2; n++) begin
            m_local_in_data = 16'h1431 + 16'(n); m_local_in_valid = 1'b1;
            tick();
        end
        m_rst = 1'b1;
        m_local_in_data = 16'h1433;
        tick();
        chk("mrst_valid", {28'd0, m_spine_out_valid}, 32'd0);
        chk("mrst_data_lo", m_spine_out_data[31:0], 32'd0);
        chk("mrst_data_hi", m_spine_out_data[63:32], 32'd0);
        chk("mrst_ready", {31'd0, m_local_in_ready}, 32'd0);
        m_rst = 1'b0; m_local_in_valid = 1'b0;
        tick();
        chk("mrst_ready_after", {31'd0, m_local_in_ready}, 32'd1);
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_spine_out_valid != '0 || m_local_out_valid) saw++;
            tick();
        end
        chk("mrst_no_stale", saw, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
